flash_byte_server: RTL and testbench
====================================

Name: flash_byte_server

Overview:
- Responder side of the flash byte-fetch interface: serves single-byte read requests from the audio fetch path, issued in forward or reverse order.
- Holds one cached 32-bit flash word. Sequential bytes within that word are served without a flash access.
- Misses are serviced through an Avalon-MM read master towards the on-board flash controller.
- Sits between the fetch/address-select logic and the flash controller, in the same clock domain.

Parameters:
- WORD_ADDR_W, 21, width of the flash word (32-bit) address (8 MB device).
- TIMEOUT, 1024, maximum cycles in WAIT_DATA before a read is abandoned.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  byte request strobe.
- req_addr  in  WORD_ADDR_W+2  byte address; [1:0] selects the byte within the word.
- req_ready  out  1  request can be accepted this cycle.
- flush  in  1  invalidate the cached word.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  8  returned byte.
- rsp_err  out  1  pulses with rsp_valid when the read timed out.
- fl_address  out  WORD_ADDR_W  Avalon word address.
- fl_read  out  1  Avalon read.
- fl_waitrequest  in  1  Avalon waitrequest.
- fl_readdata  in  32  Avalon read data.
- fl_readdatavalid  in  1  Avalon read data valid.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Outputs: rsp_valid=0, rsp_err=0, rsp_data=0x00, fl_read=0, fl_address=0, req_ready=0 during reset.
  - Cache invalid, state IDLE.
  - Reset mid-transfer: fl_read deasserts on the next edge. Any later fl_readdatavalid is ignored.
- States: IDLE, ISSUE, WAIT_DATA, RESPOND.
- IDLE:
  - req_ready=1.
  - Accept happens on req_valid & req_ready; the address is latched.
  - Hit (cache valid, tag == req_addr[top:2], no flush this cycle): go to RESPOND. rsp_valid rises the cycle after accept (latency 1).
  - Miss: go to ISSUE.
- ISSUE:
  - fl_read=1, fl_address=latched word address.
  - Both are held stable while fl_waitrequest=1.
  - On the edge with fl_waitrequest=0: fl_read drops, go to WAIT_DATA, timeout counter cleared.
- WAIT_DATA:
  - On fl_readdatavalid: capture fl_readdata, update tag, set cache valid, go to RESPOND.
  - If the counter reaches TIMEOUT-1 without data: cache invalid, rsp_data=0x00, rsp_err=1, go to RESPOND.
- RESPOND:
  - rsp_valid=1 for exactly one cycle, then IDLE. req_ready=0.
  - There is no response backpressure; the consumer must sample on the pulse.
- Byte select is little-endian: byte 0 = [7:0], byte 3 = [31:24].
- rsp_data holds its value between pulses.
- Miss latency = 1 (ISSUE) + waitrequest cycles + flash read latency + 1 (RESPOND).
- flush:
  - In IDLE: invalidates the cache on the same edge. flush together with req_valid is treated as a miss.
  - During ISSUE/WAIT_DATA: the in-flight word is still returned, but it is not cached (cache remains invalid).
- fl_readdatavalid outside WAIT_DATA: ignored, no state change.
- At most one Avalon read is outstanding; no pipelining.
- Only req_addr[1:0] changing (stepping forward or reverse within a word) is a hit. Crossing a word boundary in either direction is a miss.

Decomposition:
- flash_pkg:
  - WORD_ADDR_W default.
  - state enum fb_state_t {IDLE, ISSUE, WAIT_DATA, RESPOND}.
  - function byte_sel(word[31:0], sel[1:0]) returning [7:0].
- Sub-module flash_word_cache:
  - Tag, data and valid registers; load and invalidate inputs.
  - Combinational hit output.
  - flash_byte_server keeps the FSM, timeout counter and Avalon signalling.

Test Plan:
- Cold miss: req addr 0x000010, flash returns 0x44332211 after 3 cycles -> one fl_read with fl_address=0x000004, rsp_data=0x11, rsp_err=0.
- Forward hits: after the above, requests 0x11, 0x12, 0x13 -> no fl_read, rsp_data 0x22, 0x33, 0x44, each rsp_valid one cycle after accept.
- Reverse crossing: cached word 4, request 0x00000F with flash word 3 = 0xDDCCBBAA -> one fl_read at address 3, rsp_data=0xDD.
- Waitrequest stall: fl_waitrequest=1 for 5 cycles -> fl_read and fl_address held stable for 6 cycles, exactly one read issued.
- Timeout/flush: no readdatavalid for TIMEOUT cycles -> rsp_valid with rsp_err=1, rsp_data=0x00, next same-word request misses. flush during WAIT_DATA -> data returned, next request re-reads flash.
- Reset mid-read: rst=0 in WAIT_DATA, then a late fl_readdatavalid -> no rsp_valid, fl_read=0, first request after reset is a miss.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the flash byte server.
//   DEF_WORD_ADDR_W : default width of the 32-bit flash word address (8 MB device)
//   DEF_TIMEOUT     : default number of cycles a read may wait for data
//   fb_state_t      : responder FSM states
//   byte_sel()      : little-endian byte extraction from a 32-bit word
package flash_pkg;

    localparam int DEF_WORD_ADDR_W = 21;
    localparam int DEF_TIMEOUT     = 1024;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        RESPOND   = 2'd3
    } fb_state_t;

    // Byte 0 is the least significant byte of the word.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_word_cache.sv
// Single-entry cache holding one 32-bit flash word and its word-address tag.
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   load           : write load_tag/load_data and mark the entry valid
//   inval          : clear the valid bit (wins over load on the same edge)
//   load_tag/data  : word address and word to store
//   lookup_tag     : word address being looked up
//   hit            : combinational, entry valid and tag matches lookup_tag
//   data           : cached word
module flash_word_cache #(
    parameter int TAG_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inval,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [31:0]      load_data,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output logic [31:0]      data
);

    logic             valid_r;
    logic [TAG_W-1:0] tag_r;
    logic [31:0]      data_r;

    // Entry storage; an invalidate arriving with a load leaves the entry invalid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
            data_r  <= 32'h0000_0000;
        end else if (inval) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            tag_r   <= load_tag;
            data_r  <= load_data;
        end
    end

    assign hit  = valid_r && (tag_r == lookup_tag);
    assign data = data_r;

endmodule

// File: rtl/flash_byte_server.sv
// Responder for single-byte flash fetches. One 32-bit word is cached; bytes of
// that word are served without touching flash, anything else is fetched via an
// Avalon-MM read master with one read outstanding at most.
// Ports:
//   clk, rst                   : clock, synchronous active-low reset
//   req_valid/req_addr/req_ready : byte request (req_addr[1:0] selects the byte)
//   flush                      : invalidate the cached word
//   rsp_valid/rsp_data/rsp_err : one-cycle response pulse, err marks a timeout
//   fl_*                       : Avalon-MM read master towards the flash controller
module flash_byte_server
    import flash_pkg::*;
#(
    parameter int WORD_ADDR_W = DEF_WORD_ADDR_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic [WORD_ADDR_W+1:0] req_addr,
    output logic                   req_ready,
    input  logic                   flush,
    output logic                   rsp_valid,
    output logic [7:0]             rsp_data,
    output logic                   rsp_err,
    output logic [WORD_ADDR_W-1:0] fl_address,
    output logic                   fl_read,
    input  logic                   fl_waitrequest,
    input  logic [31:0]            fl_readdata,
    input  logic                   fl_readdatavalid
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fb_state_t              state_r;
    fb_state_t              next_state_s;
    logic [WORD_ADDR_W+1:0] addr_r;
    logic [CNT_W-1:0]       to_cnt_r;
    logic                   no_cache_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic [7:0]             rsp_data_r;
    logic                   rsp_err_r;
    logic                   fl_read_r;
    logic [WORD_ADDR_W-1:0] fl_address_r;

    logic                   accept_s;
    logic                   hit_s;
    logic                   data_in_s;
    logic                   load_s;
    logic                   timeout_s;
    logic                   inval_s;
    logic                   cache_hit_s;
    logic [31:0]            cache_data_s;

    flash_word_cache #(
        .TAG_W (WORD_ADDR_W)
    ) u_cache (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .inval      (inval_s),
        .load_tag   (addr_r[WORD_ADDR_W+1:2]),
        .load_data  (fl_readdata),
        .lookup_tag (req_addr[WORD_ADDR_W+1:2]),
        .hit        (cache_hit_s),
        .data       (cache_data_s)
    );

    // A timeout also drops the cached word so the next request goes to flash.
    assign inval_s = flush || timeout_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        hit_s        = 1'b0;
        data_in_s    = 1'b0;
        load_s       = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    // A flush in the accept cycle forces a refetch.
                    if (cache_hit_s && !flush) begin
                        hit_s        = 1'b1;
                        next_state_s = RESPOND;
                    end else begin
                        next_state_s = ISSUE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ISSUE: begin
                if (!fl_waitrequest) begin
                    next_state_s = WAIT_DATA;
                end else begin
                    next_state_s = ISSUE;
                end
            end
            WAIT_DATA: begin
                if (fl_readdatavalid) begin
                    data_in_s    = 1'b1;
                    // Word flushed while in flight is returned but never cached.
                    load_s       = !no_cache_r && !flush;
                    next_state_s = RESPOND;
                end else if (to_cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = RESPOND;
                end else begin
                    next_state_s = WAIT_DATA;
                end
            end
            RESPOND: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Datapath, timeout counter and registered interface outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r       <= '0;
            to_cnt_r     <= '0;
            no_cache_r   <= 1'b0;
            req_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 8'h00;
            rsp_err_r    <= 1'b0;
            fl_read_r    <= 1'b0;
            fl_address_r <= '0;
        end else begin
            req_ready_r <= (next_state_s == IDLE);
            rsp_valid_r <= (next_state_s == RESPOND);
            rsp_err_r   <= timeout_s;
            fl_read_r   <= (next_state_s == ISSUE);

            if (accept_s) begin
                addr_r     <= req_addr;
                no_cache_r <= 1'b0;
            end else if (flush && ((state_r == ISSUE) || (state_r == WAIT_DATA))) begin
                no_cache_r <= 1'b1;
            end

            // Only misses move the bus address, so it stays quiet on hits.
            if (accept_s && !hit_s) begin
                fl_address_r <= req_addr[WORD_ADDR_W+1:2];
            end

            if (hit_s) begin
                rsp_data_r <= byte_sel(cache_data_s, req_addr[1:0]);
            end else if (data_in_s) begin
                rsp_data_r <= byte_sel(fl_readdata, addr_r[1:0]);
            end else if (timeout_s) begin
                rsp_data_r <= 8'h00;
            end

            if (state_r == WAIT_DATA) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1);
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;
    assign fl_read    = fl_read_r;
    assign fl_address = fl_address_r;

endmodule

// File: tb/tb_flash_byte_server.sv
// Directed testbench for flash_byte_server with a small behavioural flash
// responder (configurable waitrequest stall and read latency).
module tb_flash_byte_server;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [22:0] req_addr;
    logic        req_ready;
    logic        flush;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic [20:0] fl_address;
    logic        fl_read;
    logic        fl_waitrequest;
    logic [31:0] fl_readdata;
    logic        fl_readdatavalid;

    int checks_cnt;
    int fail_cnt;
    int last_issue_cyc;
    logic last_addr_moved;

    flash_byte_server dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .flush            (flush),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .fl_address       (fl_address),
        .fl_read          (fl_read),
        .fl_waitrequest   (fl_waitrequest),
        .fl_readdata      (fl_readdata),
        .fl_readdatavalid (fl_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Flash contents seen by the bench.
    function automatic logic [31:0] flash_word(input logic [20:0] w);
        logic [7:0] b;
        b = w[7:0];
        if (w == 21'd4) return 32'h4433_2211;
        else if (w == 21'd3) return 32'hDDCC_BBAA;
        else return {b + 8'h30, b + 8'h20, b + 8'h10, b};
    endfunction

    // One request; wr = waitrequest cycles, lat = data latency (0 = never),
    // flush_at = cycle after accept in which flush is pulsed (0 = none).
    task automatic txn(input string tag, input logic [22:0] a, input logic with_flush,
                       input int wr, input int lat, input int flush_at,
                       input logic [7:0] exp_d, input logic exp_e,
                       input int exp_reads, input int exp_cyc);
        int cyc, dcnt, n_reads, issue_cyc, rsp_cyc;
        logic got, cmd_done, prev_read, addr_moved, e_obs;
        logic [7:0] d_obs;
        logic [20:0] rd_addr;
        cyc = 0; dcnt = 0; n_reads = 0; issue_cyc = 0; rsp_cyc = 0;
        got = 1'b0; cmd_done = 1'b0; prev_read = 1'b0; addr_moved = 1'b0;
        e_obs = 1'b0; d_obs = 8'h00; rd_addr = 21'd0;

        @(negedge clk);
        check_eq($sformatf("%s:req_ready", tag), req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = a;
        flush     = with_flush;
        @(posedge clk);
        #1;
        req_valid = 1'b0;

        while (!got && cyc < 1100) begin
            @(negedge clk);
            cyc++;
            fl_readdatavalid = 1'b0;
            flush = (cyc == flush_at);
            if (rsp_valid) begin
                got = 1'b1; d_obs = rsp_data; e_obs = rsp_err; rsp_cyc = cyc;
            end else if (fl_read) begin
                if (!prev_read) begin
                    n_reads++;
                    rd_addr = fl_address;
                end else if (fl_address != rd_addr) begin
                    addr_moved = 1'b1;
                end
                issue_cyc++;
                fl_waitrequest = (issue_cyc <= wr);
                if (!fl_waitrequest) begin
                    cmd_done = 1'b1;
                    dcnt = 0;
                end
            end else if (cmd_done) begin
                fl_waitrequest = 1'b0;
                dcnt++;
                if (lat > 0 && dcnt == lat) begin
                    fl_readdatavalid = 1'b1;
                    fl_readdata = flash_word(rd_addr);
                end
            end
            prev_read = fl_read;
        end
        fl_readdatavalid = 1'b0;
        fl_waitrequest   = 1'b0;
        flush            = 1'b0;

        check_eq($sformatf("%s:rsp_seen", tag), got, 1'b1);
        check_eq($sformatf("%s:data", tag), d_obs, exp_d);
        check_eq($sformatf("%s:err", tag), e_obs, exp_e);
        check_eq($sformatf("%s:reads", tag), n_reads, exp_reads);
        check_eq($sformatf("%s:latency", tag), rsp_cyc, exp_cyc);
        if (exp_reads > 0) begin
            check_eq($sformatf("%s:fl_address", tag), rd_addr, a[22:2]);
        end
        last_issue_cyc  = issue_cyc;
        last_addr_moved = addr_moved;

        @(negedge clk);
        check_eq($sformatf("%s:pulse_1cyc", tag), rsp_valid, 1'b0);
        check_eq($sformatf("%s:data_hold", tag), rsp_data, exp_d);
        check_eq($sformatf("%s:err_clear", tag), rsp_err, 1'b0);
    endtask

    initial begin
        logic seen;
        checks_cnt = 0; fail_cnt = 0;
        rst = 1'b0; req_valid = 1'b0; req_addr = 23'd0; flush = 1'b0;
        fl_waitrequest = 1'b0; fl_readdata = 32'h0; fl_readdatavalid = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst:rsp_valid", rsp_valid, 1'b0);
        check_eq("rst:rsp_err", rsp_err, 1'b0);
        check_eq("rst:rsp_data", rsp_data, 8'h00);
        check_eq("rst:fl_read", fl_read, 1'b0);
        check_eq("rst:fl_address", fl_address, 21'd0);
        check_eq("rst:req_ready", req_ready, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Cold miss, forward hits, reverse step within the word.
        txn("cold",  23'h10, 1'b0, 0, 3, 0, 8'h11, 1'b0, 1, 5);
        txn("hit11", 23'h11, 1'b0, 0, 3, 0, 8'h22, 1'b0, 0, 1);
        txn("hit12", 23'h12, 1'b0, 0, 3, 0, 8'h33, 1'b0, 0, 1);
        txn("hit13", 23'h13, 1'b0, 0, 3, 0, 8'h44, 1'b0, 0, 1);
        txn("rev12", 23'h12, 1'b0, 0, 3, 0, 8'h33, 1'b0, 0, 1);
        // Word-boundary crossings in both directions.
        txn("rev0f", 23'h0F, 1'b0, 0, 3, 0, 8'hDD, 1'b0, 1, 5);
        txn("fwd10", 23'h10, 1'b0, 0, 3, 0, 8'h11, 1'b0, 1, 5);

        // Waitrequest stall of 5 cycles.
        txn("stall", 23'h20, 1'b0, 5, 2, 0, 8'h08, 1'b0, 1, 9);
        check_eq("stall:read_cycles", last_issue_cyc, 6);
        check_eq("stall:addr_stable", last_addr_moved, 1'b0);

        // Timeout, then same word must miss.
        txn("tmo",    23'h24, 1'b0, 0, 0, 0, 8'h00, 1'b1, 1, 1026);
        txn("tmo_rd", 23'h25, 1'b0, 0, 2, 0, 8'h19, 1'b0, 1, 4);

        // Flush while waiting for data: returned but not cached.
        txn("fl_wait", 23'h28, 1'b0, 0, 3, 2, 8'h0A, 1'b0, 1, 5);
        txn("fl_rerd", 23'h29, 1'b0, 0, 2, 0, 8'h1A, 1'b0, 1, 4);
        txn("fl_hit",  23'h2A, 1'b0, 0, 2, 0, 8'h2A, 1'b0, 0, 1);
        // Flush together with a request that would otherwise hit.
        txn("fl_req",  23'h2B, 1'b1, 0, 2, 0, 8'h3A, 1'b0, 1, 4);
        txn("fl_req2", 23'h28, 1'b0, 0, 2, 0, 8'h0A, 1'b0, 0, 1);
        // Flush alone in IDLE.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        txn("fl_idle", 23'h29, 1'b0, 0, 2, 0, 8'h1A, 1'b0, 1, 4);

        // Reset during WAIT_DATA followed by a late readdatavalid.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 23'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid:issue", fl_read, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstmid:fl_read", fl_read, 1'b0);
        check_eq("rstmid:rsp_valid", rsp_valid, 1'b0);
        check_eq("rstmid:req_ready", req_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        fl_readdatavalid = 1'b1;
        fl_readdata = flash_word(21'd16);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fl_readdatavalid = 1'b0;
            if (rsp_valid || fl_read) seen = 1'b1;
        end
        check_eq("rstmid:late_rdv_ignored", seen, 1'b0);
        txn("rst_miss", 23'h40, 1'b0, 0, 2, 0, 8'h10, 1'b0, 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
